// File: rtl/stdp_synapse_array_if.sv
// Bundles the spike inputs, host weight access and current/status outputs
// of the STDP synapse array. The array is the slave; the driver is the master.
interface stdp_synapse_array_if #(
    parameter int WIDTH = 16,
    parameter int N_PRE = 4
);
    localparam int IDX_W  = $clog2(N_PRE);
    localparam int ISYN_W = WIDTH + IDX_W;

    logic [N_PRE-1:0]  pre_spike;
    logic              post_spike;
    logic              learn_en;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [WIDTH-1:0]  wr_data;
    logic [IDX_W-1:0]  rd_idx;
    logic [WIDTH-1:0]  rd_data;
    logic [ISYN_W-1:0] i_syn;
    logic              busy;

    modport master (
        output pre_spike, post_spike, learn_en, wr_en, wr_idx, wr_data, rd_idx,
        input  rd_data, i_syn, busy
    );

    modport slave (
        input  pre_spike, post_spike, learn_en, wr_en, wr_idx, wr_data, rd_idx,
        output rd_data, i_syn, busy
    );
endinterface

// File: rtl/stdp_synapse_array.sv
// Array of N_PRE plastic synapses onto one neuron. Exponential-decay traces
// record recent spikes; pending LTP/LTD flags are serviced one channel per
// cycle by a round-robin scan engine. WIDTH and N_PRE must match the
// interface instance connected to bus.
module stdp_synapse_array #(
    parameter int WIDTH         = 16,
    parameter int DECIMAL_BITS  = 7,
    parameter int N_PRE         = 4,
    parameter int TRACE_SHIFT   = 4,
    parameter int A_PLUS_SHIFT  = 5,
    parameter int A_MINUS_SHIFT = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    stdp_synapse_array_if.slave   bus
);
    localparam int IDX_W  = $clog2(N_PRE);
    localparam int ISYN_W = WIDTH + IDX_W;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1 << DECIMAL_BITS);
    localparam logic [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] T_MAX = '1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic [WIDTH-1:0]  post_trace_reg;
    logic [WIDTH-1:0]  weight_vec [N_PRE];
    logic [WIDTH-1:0]  pre_trace_vec [N_PRE];
    logic [N_PRE-1:0]  ltp_next_vec, ltd_next_vec;
    logic [WIDTH-1:0]  ltp_delta, ltd_delta;
    logic [ISYN_W-1:0] i_syn_reg, i_syn_next;
    logic              scanning;

    // Decay by t>>TRACE_SHIFT, bump by ONE on a spike, saturate at all-ones.
    function automatic logic [WIDTH-1:0] trace_step(input logic [WIDTH-1:0] t,
                                                    input logic spike);
        logic [WIDTH:0] sum;
        sum = {1'b0, t - (t >> TRACE_SHIFT)} + {1'b0, (spike ? ONE : '0)};
        return sum[WIDTH] ? T_MAX : sum[WIDTH-1:0];
    endfunction

    // Net potentiation/depression with clamping to 0..W_MAX.
    function automatic logic [WIDTH-1:0] apply_update(input logic [WIDTH-1:0] w,
                                                      input logic do_ltp,
                                                      input logic do_ltd,
                                                      input logic [WIDTH-1:0] up,
                                                      input logic [WIDTH-1:0] dn);
        logic [WIDTH+1:0] acc;
        acc = {2'b00, w};
        if (do_ltp) acc = acc + {2'b00, up};
        if (do_ltd) acc = acc - {2'b00, dn};
        if (acc[WIDTH+1])            return '0;
        if (acc > {2'b00, W_MAX})    return W_MAX;
        return acc[WIDTH-1:0];
    endfunction

    assign scanning  = (state_reg == SCAN);
    assign ltp_delta = pre_trace_vec[ptr_reg] >> A_PLUS_SHIFT;
    assign ltd_delta = post_trace_reg >> A_MINUS_SHIFT;

    genvar gi;
    generate
        for (gi = 0; gi < N_PRE; gi++) begin : g_ch
            logic [WIDTH-1:0] weight_reg, weight_next;
            logic [WIDTH-1:0] pre_trace_reg, pre_trace_next;
            logic             ltp_pend_reg, ltp_pend_next;
            logic             ltd_pend_reg, ltd_pend_next;
            logic             svc, wr_hit;

            assign svc    = scanning && (ptr_reg == IDX_W'(gi));
            assign wr_hit = bus.wr_en && (bus.wr_idx == IDX_W'(gi));

            // Per-channel next state: service clears flags, a new set wins over
            // that clear, and a host write overrides everything for the channel.
            always_comb begin
                pre_trace_next = trace_step(pre_trace_reg, bus.pre_spike[gi]);
                weight_next    = weight_reg;
                ltp_pend_next  = ltp_pend_reg;
                ltd_pend_next  = ltd_pend_reg;
                if (svc) begin
                    weight_next   = apply_update(weight_reg, ltp_pend_reg, ltd_pend_reg,
                                                 ltp_delta, ltd_delta);
                    ltp_pend_next = 1'b0;
                    ltd_pend_next = 1'b0;
                end
                if (bus.learn_en && bus.post_spike)     ltp_pend_next = 1'b1;
                if (bus.learn_en && bus.pre_spike[gi])  ltd_pend_next = 1'b1;
                if (wr_hit) begin
                    weight_next   = (bus.wr_data > W_MAX) ? W_MAX : bus.wr_data;
                    ltp_pend_next = 1'b0;
                    ltd_pend_next = 1'b0;
                end
            end

            // Per-channel state register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    weight_reg    <= ONE;
                    pre_trace_reg <= '0;
                    ltp_pend_reg  <= 1'b0;
                    ltd_pend_reg  <= 1'b0;
                end else begin
                    weight_reg    <= weight_next;
                    pre_trace_reg <= pre_trace_next;
                    ltp_pend_reg  <= ltp_pend_next;
                    ltd_pend_reg  <= ltd_pend_next;
                end
            end

            assign weight_vec[gi]    = weight_reg;
            assign pre_trace_vec[gi] = pre_trace_reg;
            assign ltp_next_vec[gi]  = ltp_pend_next;
            assign ltd_next_vec[gi]  = ltd_pend_next;
        end
    endgenerate

    // Shared postsynaptic trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) post_trace_reg <= '0;
        else     post_trace_reg <= trace_step(post_trace_reg, bus.post_spike);
    end

    // Synaptic current from the weights held before this cycle's update.
    always_comb begin
        i_syn_next = '0;
        for (int k = 0; k < N_PRE; k++) begin
            if (bus.pre_spike[k]) i_syn_next = i_syn_next + ISYN_W'(weight_vec[k] >> 2);
        end
    end

    // Registered current output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) i_syn_reg <= '0;
        else     i_syn_reg <= i_syn_next;
    end

    // FSM state register: scan state and channel pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // FSM next state: scan while any flag is (or is becoming) pending.
    always_comb begin
        state_next = state_reg;
        ptr_next   = '0;
        if ((ltp_next_vec | ltd_next_vec) != '0) begin
            state_next = SCAN;
            if (scanning)
                ptr_next = (ptr_reg == IDX_W'(N_PRE - 1)) ? '0 : ptr_reg + 1'b1;
        end else begin
            state_next = IDLE;
        end
    end

    // FSM outputs and host read port.
    always_comb begin
        bus.busy    = scanning;
        bus.i_syn   = i_syn_reg;
        bus.rd_data = '0;
        if (32'(bus.rd_idx) < N_PRE) bus.rd_data = weight_vec[bus.rd_idx];
    end
endmodule

// File: tb/tb_stdp_synapse_array.sv
// Directed bench for stdp_synapse_array with default parameters (N_PRE=4).
module tb_stdp_synapse_array;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    stdp_synapse_array_if #(.WIDTH(16), .N_PRE(4)) bus ();

    stdp_synapse_array #(
        .WIDTH(16), .DECIMAL_BITS(7), .N_PRE(4),
        .TRACE_SHIFT(4), .A_PLUS_SHIFT(5), .A_MINUS_SHIFT(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wr_en;
        logic [1:0]  wr_idx;
        logic [15:0] wr_data;
        logic [3:0]  pre;
        logic [1:0]  rd_idx;
        logic [15:0] exp_rd;
        logic [17:0] exp_isyn;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string name, input logic [1:0] idx, input logic [15:0] exp);
        bus.rd_idx = idx;
        #1;
        check(name, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic idle_inputs();
        bus.pre_spike  = '0;
        bus.post_spike = 1'b0;
        bus.learn_en   = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_idx     = '0;
        bus.wr_data    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        while (bus.busy === 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        check({name, " scan finished"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.rd_idx = '0;
        idle_inputs();

        // Reset state
        do_reset();
        for (int i = 0; i < 4; i++) read_chk($sformatf("reset rd[%0d]", i), 2'(i), 16'd128);
        check("reset i_syn", 32'(bus.i_syn), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);

        // Table: writes, reads and current path with learning disabled
        vecs[0]  = '{1'b0, 2'd0, 16'd0,     4'b0001, 2'd0, 16'd128,   18'd32};
        vecs[1]  = '{1'b0, 2'd0, 16'd0,     4'b1111, 2'd1, 16'd128,   18'd128};
        vecs[2]  = '{1'b1, 2'd2, 16'd400,   4'b0100, 2'd2, 16'd400,   18'd32};
        vecs[3]  = '{1'b0, 2'd0, 16'd0,     4'b0100, 2'd2, 16'd400,   18'd100};
        vecs[4]  = '{1'b1, 2'd3, 16'd40000, 4'b1000, 2'd3, 16'd32767, 18'd32};
        vecs[5]  = '{1'b0, 2'd0, 16'd0,     4'b1000, 2'd3, 16'd32767, 18'd8191};
        vecs[6]  = '{1'b0, 2'd0, 16'd0,     4'b1100, 2'd0, 16'd128,   18'd8291};
        vecs[7]  = '{1'b1, 2'd1, 16'd0,     4'b0000, 2'd1, 16'd0,     18'd0};
        vecs[8]  = '{1'b0, 2'd0, 16'd0,     4'b0011, 2'd1, 16'd0,     18'd32};
        vecs[9]  = '{1'b0, 2'd0, 16'd0,     4'b1111, 2'd2, 16'd400,   18'd8323};
        vecs[10] = '{1'b1, 2'd0, 16'd32767, 4'b0000, 2'd0, 16'd32767, 18'd0};
        vecs[11] = '{1'b0, 2'd0, 16'd0,     4'b0001, 2'd3, 16'd32767, 18'd8191};
        for (int v = 0; v < 12; v++) begin
            bus.wr_en     = vecs[v].wr_en;
            bus.wr_idx    = vecs[v].wr_idx;
            bus.wr_data   = vecs[v].wr_data;
            bus.pre_spike = vecs[v].pre;
            step();
            idle_inputs();
            check($sformatf("vec%0d i_syn", v), 32'(bus.i_syn), 32'(vecs[v].exp_isyn));
            check($sformatf("vec%0d busy", v), 32'(bus.busy), 32'd0);
            read_chk($sformatf("vec%0d rd", v), vecs[v].rd_idx, vecs[v].exp_rd);
        end

        // Current path and trace decay
        do_reset();
        bus.pre_spike = 4'b0001;
        step();
        bus.pre_spike = 4'b0000;
        check("cur i_syn", 32'(bus.i_syn), 32'd32);
        check("cur trace0 c1", 32'(dut.g_ch[0].pre_trace_reg), 32'd128);
        check("cur busy c1", 32'(bus.busy), 32'd0);
        step();
        check("cur trace0 c2", 32'(dut.g_ch[0].pre_trace_reg), 32'd120);
        check("cur i_syn c2", 32'(bus.i_syn), 32'd0);
        step();
        check("cur trace0 c3", 32'(dut.g_ch[0].pre_trace_reg), 32'd113);
        check("cur busy c3", 32'(bus.busy), 32'd0);

        // LTP on channel 2
        do_reset();
        bus.pre_spike = 4'b0100;
        step();
        bus.pre_spike  = 4'b0000;
        bus.post_spike = 1'b1;
        bus.learn_en   = 1'b1;
        step();
        idle_inputs();
        for (int c = 2; c <= 5; c++) begin
            check($sformatf("ltp busy c%0d", c), 32'(bus.busy), 32'd1);
            if (c == 4) check("ltp trace2 at service", 32'(dut.g_ch[2].pre_trace_reg), 32'd106);
            step();
        end
        check("ltp busy c6", 32'(bus.busy), 32'd0);
        read_chk("ltp rd2", 2'd2, 16'd131);
        read_chk("ltp rd0", 2'd0, 16'd128);
        read_chk("ltp rd1", 2'd1, 16'd128);
        read_chk("ltp rd3", 2'd3, 16'd128);

        // LTD down to the floor on channel 1
        do_reset();
        bus.wr_en = 1'b1; bus.wr_idx = 2'd1; bus.wr_data = 16'd1;
        step();
        idle_inputs();
        bus.post_spike = 1'b1;
        step();
        idle_inputs();
        bus.pre_spike = 4'b0010;
        bus.learn_en  = 1'b1;
        step();
        idle_inputs();
        check("ltd busy d", 32'(bus.busy), 32'd1);
        step();
        check("ltd busy e", 32'(bus.busy), 32'd1);
        step();
        check("ltd busy f", 32'(bus.busy), 32'd0);
        read_chk("ltd rd1", 2'd1, 16'd0);
        bus.pre_spike = 4'b0010;
        step();
        idle_inputs();
        check("ltd i_syn", 32'(bus.i_syn), 32'd0);

        // Ceiling: clamped write and LTP on a saturated weight
        do_reset();
        bus.wr_en = 1'b1; bus.wr_idx = 2'd3; bus.wr_data = 16'd40000;
        step();
        idle_inputs();
        read_chk("ceil wr rd3", 2'd3, 16'd32767);
        bus.pre_spike = 4'b1000;
        step();
        idle_inputs();
        bus.post_spike = 1'b1;
        bus.learn_en   = 1'b1;
        step();
        idle_inputs();
        check("ceil busy", 32'(bus.busy), 32'd1);
        wait_idle("ceil", 10);
        read_chk("ceil ltp rd3", 2'd3, 16'd32767);

        // Host write colliding with service of channel 0
        do_reset();
        bus.pre_spike = 4'b0001;
        step();
        idle_inputs();
        bus.post_spike = 1'b1;
        bus.learn_en   = 1'b1;
        step();
        idle_inputs();
        check("coll busy", 32'(bus.busy), 32'd1);
        bus.wr_en = 1'b1; bus.wr_idx = 2'd0; bus.wr_data = 16'd500;
        step();
        idle_inputs();
        read_chk("coll rd0", 2'd0, 16'd500);
        check("coll ltp0 clear", 32'(dut.g_ch[0].ltp_pend_reg), 32'd0);
        check("coll ltd0 clear", 32'(dut.g_ch[0].ltd_pend_reg), 32'd0);
        wait_idle("coll", 10);
        read_chk("coll rd0 end", 2'd0, 16'd500);

        // Reset in the middle of a scan
        do_reset();
        bus.pre_spike = 4'b1111;
        step();
        idle_inputs();
        bus.post_spike = 1'b1;
        bus.learn_en   = 1'b1;
        step();
        idle_inputs();
        step();
        check("mid busy before rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid busy in rst", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) read_chk($sformatf("mid rd[%0d] in rst", i), 2'(i), 16'd128);
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("mid busy after rst c%0d", c), 32'(bus.busy), 32'd0);
        end
        for (int i = 0; i < 4; i++) read_chk($sformatf("mid rd[%0d] after", i), 2'(i), 16'd128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/stdp_synapse_array.md
STDP_SYNAPSE_ARRAY -- requirements
Module: stdp_synapse_array

Interface
REQ-001 SHALL have parameter WIDTH, default 16: weight/trace width in bits.
REQ-002 SHALL have parameter DECIMAL_BITS, default 7: fixed-point fraction bits, with ONE = 1<<DECIMAL_BITS.
REQ-003 SHALL have parameter N_PRE, default 4: number of presynaptic channels (2..16).
REQ-004 SHALL have parameters TRACE_SHIFT=4, A_PLUS_SHIFT=5, A_MINUS_SHIFT=6: trace decay shift, LTP shift and LTD shift.
REQ-005 SHALL have ports `clk  in  1`: the single clock, rising edge.
REQ-006 SHALL have port `rst  in  1`: the reset, asynchronous and active-high.
REQ-007 SHALL have port `pre_spike  in  N_PRE`: per-channel presynaptic spike, one bit per channel, level per cycle.
REQ-008 SHALL have port `post_spike  in  1`: postsynaptic spike.
REQ-009 SHALL have port `learn_en  in  1`: gates the creation of new weight updates.
REQ-010 SHALL have ports `wr_en  in  1`, `wr_idx  in  clog2(N_PRE)`, `wr_data  in  WIDTH`: host weight write.
REQ-011 SHALL have ports `rd_idx  in  clog2(N_PRE)`, `rd_data  out  WIDTH`: host weight read.
REQ-012 SHALL have port `i_syn  out  WIDTH+clog2(N_PRE)`: summed synaptic current.
REQ-013 SHALL have port `busy  out  1`: high while the update engine is in SCAN.

Function
REQ-014 Weights SHALL be unsigned, per channel, in the range 0..W_MAX, where W_MAX = (1<<(WIDTH-1))-1.
- pre_trace[k] is unsigned per channel; post_trace is a single shared unsigned register.
REQ-015 Each trace SHALL update every cycle as next = t - (t>>TRACE_SHIFT), plus ONE if the matching spike is high that cycle.
- The sum saturates at 2^WIDTH-1.
REQ-016 pre_spike[k]=1 with learn_en=1 SHALL set sticky flag ltd_pend[k].
- post_spike=1 with learn_en=1 SHALL set ltp_pend[k] for all k.
- With learn_en=0, no flag is set; flags already pending are still serviced.
REQ-017 The FSM SHALL have two states, IDLE and SCAN, with a channel pointer ptr.
- IDLE -> SCAN at the clock edge after any flag is set; ptr = 0 on entry.
REQ-018 In SCAN, each cycle SHALL service channel ptr using trace register values current in that cycle.
- ltp_pend: w += pre_trace[ptr]>>A_PLUS_SHIFT.
- ltd_pend: w -= post_trace>>A_MINUS_SHIFT.
- Both pending: net of the two.
- Result saturates to 0..W_MAX.
- Both flags for ptr clear; ptr advances modulo N_PRE.
REQ-019 SCAN -> IDLE SHALL occur at the edge where no flag remains set after servicing.
REQ-020 A flag set in the same cycle its channel is serviced SHALL remain set (set wins over clear).
REQ-021 wr_en=1 SHALL load weight[wr_idx] = min(wr_data, W_MAX) and clear both flags of that channel.
- wr_en overrides a same-cycle service of that channel.
- wr_idx >= N_PRE is ignored.
REQ-022 rd_data SHALL be combinational weight[rd_idx].
- rd_data = 0 when rd_idx >= N_PRE.
REQ-023 i_syn SHALL be registered with 1-cycle latency: i_syn = sum over k of (pre_spike[k] ? weight[k]>>2 : 0).
- The weight used is the value before that cycle's update.
REQ-024 busy SHALL be 1 exactly in SCAN cycles.

Reset
REQ-025 While rst=1, the block SHALL asynchronously set:
- weight[k] = ONE for all k; all traces = 0; all flags = 0;
- FSM = IDLE, ptr = 0; i_syn = 0; busy = 0.
REQ-026 rst asserted mid-SCAN SHALL abort the scan with no partial weight update retained beyond the reset values.

Verification (defaults, N_PRE=4)
REQ-027 The bench SHALL cover the reset case: after rst pulse -> rd_data = 128 for idx 0..3, i_syn = 0, busy = 0.
REQ-028 The bench SHALL cover the current path: pre_spike=0001 for one cycle with learn_en=0 -> i_syn = 32 the next cycle; pre_trace[0] = 128, then 120, then 113; busy stays 0.
REQ-029 The bench SHALL cover LTP:
- Stimulus: cycle 0 pre_spike=0100 with learn_en=0; cycle 1 post_spike=1 with learn_en=1.
- Response: busy high in cycles 2-5; ch2 serviced in cycle 4 with pre_trace[2] = 106; weight[2] = 131; other channels stay 128.
REQ-030 The bench SHALL cover LTD floor:
- Stimulus: write weight[1] = 1; post_spike; next cycle pre_spike=0010 with learn_en=1.
- Response: weight[1] = 0; a later pre_spike=0010 gives i_syn = 0.
REQ-031 The bench SHALL cover the ceiling and collision cases:
- Write weight[3] = 40000 -> reads 32767; an LTP on ch3 keeps it at 32767.
- wr_en to ch0 in the same cycle ch0 is serviced -> written value is retained and ch0 flags are cleared.
REQ-032 The bench SHALL cover reset mid-scan: rst during busy=1 -> busy = 0 and all weights = 128 immediately; no update occurs after rst deasserts.
